// File: rtl/interrupt_sequencer.sv
// Interrupt capture, masking and entry sequencing beside the instruction decoder.
// Optional per-source vector table enabled by defining INTSEQ_VECTOR_TABLE_EN.
module interrupt_sequencer #(
   parameter int                  NUM_SRC     = 4,
   parameter int                  PC_WIDTH    = 13,
   parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = 13'h004
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          q_count,
   input  logic [NUM_SRC-1:0]  src_in,
   input  logic [NUM_SRC-1:0]  ie_mask,
   input  logic [NUM_SRC-1:0]  flag_clr,
   input  logic                gie_wr_en,
   input  logic                gie_wr_data,
   input  logic                retfie_q3,
   output logic                gie,
   output logic [NUM_SRC-1:0]  flags,
   output logic                int_pending,
   output logic                force_nop,
   output logic                pc_push_en,
   output logic                pc_vector_en,
   output logic [PC_WIDTH-1:0] pc_vector,
   output logic                instr_flush,
   output logic                busy
);

   typedef enum logic {IDLE, ENTRY} state_t;

   state_t             state_reg, state_next;
   logic [NUM_SRC-1:0] sync1_reg, sync2_reg, prev_reg;
   logic [NUM_SRC-1:0] flags_reg, flags_next, rise;
   logic               gie_reg, gie_next;
   logic               q3, entry_start, entry_done;

   assign q3          = (q_count == 2'd3);
   assign int_pending = gie_reg & (|(flags_reg & ie_mask));
   assign entry_start = (state_reg == IDLE) && int_pending && q3;
   assign entry_done  = (state_reg == ENTRY) && q3;
   assign flags       = flags_reg;
   assign gie         = gie_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
         flags_reg <= '0;
         gie_reg   <= 1'b0;
      end else begin
         sync1_reg <= src_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         flags_reg <= flags_next;
         gie_reg   <= gie_next;
      end
   end

   // A new edge beats a simultaneous software clear.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_flag
         assign rise[gi]       = sync2_reg[gi] & ~prev_reg[gi];
         assign flags_next[gi] = rise[gi] | (flags_reg[gi] & ~flag_clr[gi]);
      end
   endgenerate

   always_comb begin
      gie_next = gie_reg;
      if (entry_done)
         gie_next = 1'b0;
      else if (gie_wr_en)
         gie_next = gie_wr_data;
      else if (retfie_q3)
         gie_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (int_pending && q3) state_next = ENTRY;
         ENTRY:   if (q3) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The jump controls fire in the final q3 of the forced-NOP cycle.
   always_comb begin
      busy         = 1'b0;
      force_nop    = 1'b0;
      pc_push_en   = 1'b0;
      pc_vector_en = 1'b0;
      instr_flush  = 1'b0;
      if (state_reg == ENTRY) begin
         busy      = 1'b1;
         force_nop = 1'b1;
         if (q3) begin
            pc_push_en   = 1'b1;
            pc_vector_en = 1'b1;
            instr_flush  = 1'b1;
         end
      end
   end

`ifdef INTSEQ_VECTOR_TABLE_EN
   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [NUM_SRC-1:0] active;

   assign active = flags_reg & ie_mask;

   // Descending scan so the lowest-numbered active source wins.
   always_comb begin
      idx_next = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i])
            idx_next = IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         idx_reg <= '0;
      else if (entry_start)
         idx_reg <= idx_next;
   end

   assign pc_vector = VECTOR_ADDR + PC_WIDTH'({idx_reg, 1'b0});
`else
   logic unused_entry_start;
   assign unused_entry_start = entry_start;
   assign pc_vector          = VECTOR_ADDR;
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized and directed bench for interrupt_sequencer against a delay-line /
// countdown reference model.
module tb_interrupt_sequencer;

   logic        clk;
   logic        rst;
   logic [1:0]  q_count;
   logic [3:0]  src_in, ie_mask, flag_clr;
   logic        gie_wr_en, gie_wr_data, retfie_q3;
   logic        gie, int_pending, force_nop, pc_push_en, pc_vector_en, instr_flush, busy;
   logic [3:0]  flags;
   logic [12:0] pc_vector;

   interrupt_sequencer #(.NUM_SRC(4), .PC_WIDTH(13), .VECTOR_ADDR(13'h004)) dut (
      .clk(clk), .rst(rst), .q_count(q_count), .src_in(src_in), .ie_mask(ie_mask),
      .flag_clr(flag_clr), .gie_wr_en(gie_wr_en), .gie_wr_data(gie_wr_data),
      .retfie_q3(retfie_q3), .gie(gie), .flags(flags), .int_pending(int_pending),
      .force_nop(force_nop), .pc_push_en(pc_push_en), .pc_vector_en(pc_vector_en),
      .pc_vector(pc_vector), .instr_flush(instr_flush), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int push_seen = 0;
   logic [12:0] last_vec = '0;

   // Reference model: src history of past edges, entry countdown, gie bit.
   logic [3:0] m_flags, h1, h2, h3;
   bit         m_gie;
   int         m_left;
   int         m_idx;

`ifdef INTSEQ_VECTOR_TABLE_EN
   localparam bit TABLE = 1'b1;
`else
   localparam bit TABLE = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [12:0] exp_vector();
      if (TABLE) return 13'(13'h004 + 2 * m_idx);
      return 13'h004;
   endfunction

   task automatic model_reset();
      m_flags = '0; h1 = '0; h2 = '0; h3 = '0;
      m_gie = 1'b0; m_left = 0; m_idx = 0;
   endtask

   // One clock: compare outputs at negedge, advance model, cross posedge.
   task automatic step();
      logic [3:0] rise, nflags;
      bit pend;
      @(negedge clk);
      pend = m_gie && ((m_flags & ie_mask) != 4'b0);
      check_val("flags", 32'(flags), 32'(m_flags));
      check_val("gie", 32'(gie), 32'(m_gie));
      check_val("int_pending", 32'(int_pending), 32'(pend));
      check_val("busy", 32'(busy), 32'(m_left > 0));
      check_val("force_nop", 32'(force_nop), 32'(m_left > 0));
      check_val("pc_push_en", 32'(pc_push_en), 32'(m_left == 1));
      check_val("pc_vector_en", 32'(pc_vector_en), 32'(m_left == 1));
      check_val("instr_flush", 32'(instr_flush), 32'(m_left == 1));
      check_val("pc_vector", 32'(pc_vector), 32'(exp_vector()));
      if (pc_push_en) begin
         push_seen++;
         last_vec = pc_vector;
         $display("entry %0d: t=%0t vector=%03h flags=%b mask=%b", push_seen, $time, pc_vector, flags, ie_mask);
      end
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = src_in;
      if (m_left == 1)      m_gie = 1'b0;
      else if (gie_wr_en)   m_gie = gie_wr_data;
      else if (retfie_q3)   m_gie = 1'b1;
      nflags = (m_flags & ~flag_clr) | rise;
      if (m_left > 0)
         m_left--;
      else if (pend && q_count == 2'd3) begin
         m_left = 4;
         m_idx  = lowest(m_flags & ie_mask);
      end
      m_flags = nflags;
      @(posedge clk);
      #1;
      q_count = q_count + 2'd1;
   endtask

   initial begin
      int base;
      rst = 1'b0; q_count = 2'd0; src_in = '0; ie_mask = '0; flag_clr = '0;
      gie_wr_en = 1'b0; gie_wr_data = 1'b0; retfie_q3 = 1'b0;
      model_reset();
      #2;
      check_val("rst_gie", 32'(gie), 32'd0);
      check_val("rst_flags", 32'(flags), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_vector", 32'(pc_vector), 32'h004);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Enable source 0 and pulse it; entry follows at the next q3.
      gie_wr_en = 1'b1; gie_wr_data = 1'b1; ie_mask = 4'b0001;
      step();
      gie_wr_en = 1'b0;
      src_in = 4'b0001;
      step();
      src_in = 4'b0000;
      repeat (14) step();
      check_val("p1_entries", 32'(push_seen), 32'd1);

      // Masked source sets its flag but does not enter until unmasked.
      flag_clr = 4'hF; step(); flag_clr = '0;
      ie_mask = '0; gie_wr_en = 1'b1; gie_wr_data = 1'b1; step(); gie_wr_en = 1'b0;
      src_in = 4'b0100; step(); src_in = '0;
      repeat (8) step();
      check_val("p3_masked", 32'(push_seen), 32'd1);
      ie_mask = 4'b0100;
      repeat (10) step();
      check_val("p3_unmasked", 32'(push_seen), 32'd2);

      // Set beats a coincident clear; a held level sets only once.
      flag_clr = 4'hF; step(); flag_clr = '0;
      src_in = 4'b0010; step(); step();
      flag_clr = 4'b0010; step(); flag_clr = '0;
      check_val("p4_set_wins", 32'(flags[1]), 32'd1);
      repeat (20) step();
      flag_clr = 4'b0010; step(); flag_clr = '0;
      repeat (5) step();
      check_val("p4_held_level", 32'(flags[1]), 32'd0);
      src_in = '0;
      repeat (3) step();

      // Reset in the middle of an entry sequence.
      base = push_seen;
      gie_wr_en = 1'b1; gie_wr_data = 1'b1; ie_mask = 4'b0010; step(); gie_wr_en = 1'b0;
      src_in = 4'b0010; step(); src_in = '0;
      for (int k = 0; k < 40; k++) begin
         if (busy && q_count == 2'd1) break;
         step();
      end
      check_val("p5_reach", 32'(busy && q_count == 2'd1), 32'd1);
      rst = 1'b0;
      #1;
      check_val("p5_busy", 32'(busy), 32'd0);
      check_val("p5_gie", 32'(gie), 32'd0);
      check_val("p5_push", 32'(pc_push_en), 32'd0);
      model_reset();
      #2 rst = 1'b1;
      repeat (8) step();
      check_val("p5_no_push", 32'(push_seen), 32'(base));
      for (int k = 0; k < 4; k++) begin
         if (q_count == 2'd3) break;
         step();
      end
      retfie_q3 = 1'b1; step(); retfie_q3 = 1'b0;
      check_val("p5_retfie", 32'(gie), 32'd1);

      // Two simultaneous sources: table picks the lower index.
      ie_mask = '0; flag_clr = 4'hF; step(); flag_clr = '0;
      src_in = 4'b1100; step(); src_in = '0;
      repeat (4) step();
      ie_mask = 4'hF;
      repeat (10) step();
      check_val("p6_vector", 32'(last_vec), TABLE ? 32'h008 : 32'h004);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(7) == 0) src_in[b] = ~src_in[b];
         if ($urandom_range(15) == 0) ie_mask = 4'($urandom);
         flag_clr = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
         gie_wr_en = ($urandom_range(19) == 0);
         gie_wr_data = 1'($urandom);
         retfie_q3 = (q_count == 2'd3) && ($urandom_range(3) == 0);
         step();
      end
      src_in = '0; flag_clr = '0; gie_wr_en = 1'b0; retfie_q3 = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Captures peripheral interrupt events, masks them against INTCON-style enables, and sequences interrupt entry into the core.
- Waits for the current instruction to finish at the Q4 boundary, injects one forced-NOP instruction cycle, then pushes the PC, loads the vector, flushes the fetch and clears GIE.
- Sits beside instruction_decoder and drives the PC/stack jump controls through the same interface used by CALL.
- Re-arms on RETFIE.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- PC_WIDTH, 13, program counter width.
- VECTOR_ADDR, 13'h004, interrupt vector address.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- q_count  in  2  instruction phase counter, 0..3; 3 is the last cycle of an instruction.
- src_in  in  NUM_SRC  raw asynchronous interrupt sources; rising-edge sensitive.
- ie_mask  in  NUM_SRC  per-source enables.
- flag_clr  in  NUM_SRC  software clear of flags, one cycle per bit.
- gie_wr_en  in  1  software write strobe for GIE.
- gie_wr_data  in  1  GIE write value.
- retfie_q3  in  1  decoder is executing RETFIE and q_count==3.
- gie  out  1  global interrupt enable.
- flags  out  NUM_SRC  latched interrupt flags.
- int_pending  out  1  gie & |(flags & ie_mask).
- force_nop  out  1  decoder must treat instr_current as NOP.
- pc_push_en  out  1  push the current PC onto the stack.
- pc_vector_en  out  1  load pc_vector into the PC.
- pc_vector  out  PC_WIDTH  vector target.
- instr_flush  out  1  discard the fetched instruction.
- busy  out  1  entry sequence in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: gie=0, flags=0, force_nop=0, pc_push_en=0, pc_vector_en=0, instr_flush=0, busy=0, pc_vector=VECTOR_ADDR.
  - Synchronizers clear and the state machine returns to IDLE.
  - Asserting reset mid-sequence aborts the sequence; no push occurs.
- Event capture:
  - Each src_in bit passes through a 2-flop synchronizer plus a previous-value register.
  - A rising edge sets flags[i] at the 3rd rising clk edge after src_in[i] goes high.
  - A level held high sets the flag only once.
  - If set and flag_clr[i] coincide, set wins.
  - Flags are set regardless of ie_mask and gie.
- State machine:
  - IDLE:
    - If int_pending and q_count==3, go to ENTRY on that edge.
    - The current instruction's own q3 actions complete normally.
    - busy=0.
  - ENTRY:
    - busy=1 and force_nop=1 for all four cycles (q_count 0..3).
    - Leave ENTRY only at q_count==3.
    - In that q3 cycle, combinationally assert pc_push_en=1, pc_vector_en=1 and instr_flush=1 for exactly one cycle.
    - gie clears to 0 at the same edge; the next state is IDLE.
  - Entry latency is exactly 5 cycles from the q3 sample to the cycle after the vector load.
  - If the interrupted instruction was itself a jump or flush at its q3, the PC it produced is the PC that gets pushed.
  - int_pending dropping during ENTRY (flag cleared or mask changed) does not abort the sequence.
- GIE update priority, highest first:
  1. Entry clear.
  2. gie_wr_en.
  3. retfie_q3 (sets gie=1).
- int_pending is combinational and never asserts while gie=0.
- Nesting is impossible by construction, because GIE=0 after entry.
- Flags are not cleared by hardware; software must clear them.

Optional Feature:
- Macro: INTSEQ_VECTOR_TABLE_EN.
- Defined:
  - At ENTRY start, latch the lowest-numbered i with flags[i] & ie_mask[i].
  - pc_vector = VECTOR_ADDR + 2*i, with width truncated to PC_WIDTH.
  - The latched index is held until the next entry.
  - Source 0 has the highest priority.
- Not defined: pc_vector is constant VECTOR_ADDR and no index register exists.

Test Plan:
1. Reset → outputs at reset values. Then gie_wr_en=1, gie_wr_data=1, ie_mask=4'b0001; pulse src_in[0] → flags=4'b0001 three edges later; int_pending=1.
2. Pending sampled at q_count==3 → next 4 cycles force_nop=1. In the final q3, pc_push_en, pc_vector_en and instr_flush are each high exactly 1 cycle, pc_vector=13'h004, and gie=0 at the following edge.
3. ie_mask=0 with src_in[2] pulsed → flags[2]=1, int_pending=0, no entry. Then set ie_mask[2]=1 with gie=1 → entry begins at the next q3.
4. flag_clr[1] and a synchronized rising edge on src 1 in the same cycle → flags[1]=1. Hold src_in[1] high for 20 cycles, then clear the flag → it stays 0.
5. Assert rst during ENTRY at q_count==1 → no pc_push_en ever asserts; gie=0, busy=0 immediately. retfie_q3 pulse afterwards → gie=1.
6. With INTSEQ_VECTOR_TABLE_EN, flags=4'b1100 and ie_mask=4'b1111 → pc_vector=13'h008. Without the macro → pc_vector=13'h004.
